// File: rtl/jtag_tap_driver_if.sv
// Command/response handshake bundle between a JTAG scan initiator (master) and jtag_tap_driver (slave).
interface jtag_tap_driver_if #(
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [LEN_W-1:0]   cmd_len;
   logic [MAX_LEN-1:0] cmd_data;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [MAX_LEN-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/jtag_tap_driver.sv
// JTAG initiator: turns scan/idle/reset commands into TCK/TMS/TDI waveforms and returns captured TDO.
// Optional feature macro JTAG_TAP_DRIVER_TLR_EN: op 11 walks the TAP through Test-Logic-Reset.
module jtag_tap_driver #(
   parameter int MAX_LEN = 32,
   parameter int CLK_DIV = 4,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   jtag_tap_driver_if.slave bus,
   output logic             busy,
   output logic             tck,
   output logic             tms,
   output logic             tdi,
   input  logic             tdo
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [1:0] OP_DR  = 2'b00;
   localparam logic [1:0] OP_IR  = 2'b01;
   localparam logic [1:0] OP_RTI = 2'b10;
   localparam logic [1:0] OP_RST = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_SHIFT, S_TRL, S_RTI, S_TLR, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               tck_q, tck_d;
   logic               tms_q, tms_d;
   logic               tdi_q, tdi_d;
   logic [CNT_W-1:0]   bit_q, bit_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               is_ir_q, is_ir_d;
   logic [MAX_LEN-1:0] data_q, data_d;
   logic [MAX_LEN-1:0] mask_q, mask_d;
   logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
   logic               rsp_valid_q, rsp_valid_d;

   logic               cmd_ready_s;
   logic               accept_s;
   logic [LEN_W-1:0]   cmd_len_s;
   logic [CNT_W-1:0]   last_cnt_s;
   logic               last_s;
   logic               half_end_s;

   assign cmd_ready_s = (state_q == S_IDLE) & ~rsp_valid_q;
   assign accept_s    = bus.cmd_valid & cmd_ready_s;
   assign cmd_len_s   = (bus.cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cmd_len;
   assign half_end_s  = (div_q == DIV_LAST);
   assign last_s      = (bit_q == (last_cnt_s - CNT_W'(1)));

   // Number of TCK cycles spent in each active state
   always_comb begin
      case (state_q)
         S_HDR:          last_cnt_s = is_ir_q ? CNT_W'(4) : CNT_W'(3);
         S_SHIFT, S_RTI: last_cnt_s = CNT_W'(len_q);
         S_TRL:          last_cnt_s = CNT_W'(2);
         S_TLR:          last_cnt_s = CNT_W'(6);
         default:        last_cnt_s = CNT_W'(1);
      endcase
   end

   // Next-state and waveform generation; tms/tdi only move when a new TCK cycle begins
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      tck_d       = tck_q;
      tms_d       = tms_q;
      tdi_d       = tdi_q;
      bit_d       = bit_q;
      len_d       = len_q;
      is_ir_d     = is_ir_q;
      data_d      = data_q;
      mask_d      = mask_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               len_d      = cmd_len_s;
               is_ir_d    = (bus.cmd_op == OP_IR);
               data_d     = bus.cmd_data;
               mask_d     = MAX_LEN'(1);
               rsp_data_d = '0;
               div_d      = '0;
               tck_d      = 1'b0;
               bit_d      = '0;
               tdi_d      = 1'b0;
               case (bus.cmd_op)
                  OP_DR, OP_IR: begin
                     if (cmd_len_s == '0) begin
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                        tms_d       = 1'b0;
                     end else begin
                        state_d = S_HDR;
                        tms_d   = 1'b1;
                     end
                  end
                  OP_RTI: begin
                     tms_d = 1'b0;
                     if (cmd_len_s == '0) begin
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                     end else begin
                        state_d = S_RTI;
                     end
                  end
                  OP_RST: begin
`ifdef JTAG_TAP_DRIVER_TLR_EN
                     state_d = S_TLR;
                     tms_d   = 1'b1;
`else
                     state_d     = S_DONE;
                     rsp_valid_d = 1'b1;
                     tms_d       = 1'b0;
`endif
                  end
                  default: begin
                     state_d     = S_DONE;
                     rsp_valid_d = 1'b1;
                     tms_d       = 1'b0;
                  end
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HDR, S_SHIFT, S_TRL, S_RTI, S_TLR: begin
            if (!half_end_s) begin
               div_d = div_q + DIV_W'(1);
            end else if (!tck_q) begin
               // Rising edge: TDO has been stable since the previous falling edge
               div_d = '0;
               tck_d = 1'b1;
               if ((state_q == S_SHIFT) && tdo) begin
                  rsp_data_d = rsp_data_q | mask_q;
               end else begin
                  rsp_data_d = rsp_data_q;
               end
            end else begin
               div_d = '0;
               tck_d = 1'b0;
               bit_d = bit_q + CNT_W'(1);
               case (state_q)
                  S_HDR: begin
                     if (last_s) begin
                        state_d = S_SHIFT;
                        bit_d   = '0;
                        tms_d   = (len_q == LEN_W'(1));
                        tdi_d   = data_q[0];
                     end else begin
                        tms_d = is_ir_q && (bit_q == '0);
                     end
                  end
                  S_SHIFT: begin
                     data_d = data_q >> 1;
                     mask_d = mask_q << 1;
                     if (last_s) begin
                        state_d = S_TRL;
                        bit_d   = '0;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                     end else begin
                        tms_d = ((bit_q + CNT_W'(2)) == CNT_W'(len_q));
                        tdi_d = data_q[1];
                     end
                  end
                  default: begin
                     if (last_s) begin
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                        tms_d       = 1'b0;
                        tdi_d       = 1'b0;
                     end else begin
                        tms_d = (state_q == S_TLR) && (bit_q < CNT_W'(4));
                     end
                  end
               endcase
            end
         end
         S_DONE: begin
            if (bus.rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         tck_q       <= 1'b0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
         bit_q       <= '0;
         len_q       <= '0;
         is_ir_q     <= 1'b0;
         data_q      <= '0;
         mask_q      <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         bit_q       <= bit_d;
         len_q       <= len_d;
         is_ir_q     <= is_ir_d;
         data_q      <= data_d;
         mask_q      <= mask_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_s;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign busy          = (state_q != S_IDLE);
   assign tck           = tck_q;
   assign tms           = tms_q;
   assign tdi           = tdi_q;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Directed bench for jtag_tap_driver against a behavioural target TAP (8-bit DR, 4-bit IR).
module tb_jtag_tap_driver;
   localparam int MAX_LEN = 32;
   localparam int CLK_DIV = 4;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   typedef enum logic [3:0] {
      T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PDR, T_EX2DR, T_UPDR,
      T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PIR, T_EX2IR, T_UPIR
   } tap_e;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy, tck, tms, tdi;
   logic tdo = 1'b0;
   logic tap_trst = 1'b0;

   jtag_tap_driver_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

   jtag_tap_driver #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy),
      .tck   (tck),
      .tms   (tms),
      .tdi   (tdi),
      .tdo   (tdo)
   );

   always #5 clk = ~clk;

   // Target TAP model
   tap_e       tap_st = T_RTI;
   logic [7:0] dr_reg = 8'h3C;
   logic [7:0] dr_sr  = 8'h00;
   logic [3:0] ir_reg = 4'h0;
   logic [3:0] ir_sr  = 4'h0;

   function automatic tap_e tap_next(input tap_e s, input logic m);
      case (s)
         T_TLR:   return m ? T_TLR   : T_RTI;
         T_RTI:   return m ? T_SELDR : T_RTI;
         T_SELDR: return m ? T_SELIR : T_CAPDR;
         T_CAPDR: return m ? T_EX1DR : T_SHDR;
         T_SHDR:  return m ? T_EX1DR : T_SHDR;
         T_EX1DR: return m ? T_UPDR  : T_PDR;
         T_PDR:   return m ? T_EX2DR : T_PDR;
         T_EX2DR: return m ? T_UPDR  : T_SHDR;
         T_UPDR:  return m ? T_SELDR : T_RTI;
         T_SELIR: return m ? T_TLR   : T_CAPIR;
         T_CAPIR: return m ? T_EX1IR : T_SHIR;
         T_SHIR:  return m ? T_EX1IR : T_SHIR;
         T_EX1IR: return m ? T_UPIR  : T_PIR;
         T_PIR:   return m ? T_EX2IR : T_PIR;
         T_EX2IR: return m ? T_UPIR  : T_SHIR;
         default: return m ? T_SELDR : T_RTI;
      endcase
   endfunction

   always @(posedge tck or posedge tap_trst) begin
      if (tap_trst) begin
         tap_st <= T_RTI;
      end else begin
         case (tap_st)
            T_CAPDR: dr_sr  <= dr_reg;
            T_SHDR:  dr_sr  <= {tdi, dr_sr[7:1]};
            T_UPDR:  dr_reg <= dr_sr;
            T_CAPIR: ir_sr  <= 4'b0001;
            T_SHIR:  ir_sr  <= {tdi, ir_sr[3:1]};
            T_UPIR:  ir_reg <= ir_sr;
            default: ;
         endcase
         tap_st <= tap_next(tap_st, tms);
      end
   end

   always @(negedge tck) begin
      tdo <= (tap_st == T_SHDR) ? dr_sr[0] : ((tap_st == T_SHIR) ? ir_sr[0] : 1'b0);
   end

   // TCK monitor: rising-edge count, TMS seen at each rise, last TCK period
   int unsigned rises = 0;
   logic        tms_log [0:511];
   time         last_rise = 0;
   time         tck_period = 0;

   always @(posedge tck) begin
      tms_log[rises] <= tms;
      rises          <= rises + 1;
      tck_period     <= $time - last_rise;
      last_rise      <= $time;
   end

   int checks = 0;
   int fails  = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] tms_seq(input int unsigned base, input int unsigned n);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < 64; k++) begin
         if (k < n) v[k] = tms_log[base + k];
      end
      return v;
   endfunction

   task automatic send_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len, input logic [31:0] data);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("cmd_accept", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_len   = len;
      bus.cmd_data  = data;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat, output logic [31:0] data);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.rsp_valid && lat < 2000);
      check_eq("rsp_seen", 64'(bus.rsp_valid), 64'd1);
      data = bus.rsp_data;
   endtask

   task automatic consume();
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
   endtask

   int unsigned base;
   int          lat;
   logic [31:0] rdata;

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_len   = '0;
      bus.cmd_data  = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_tck",  64'(tck), 64'd0);
      check_eq("rst_tms",  64'(tms), 64'd1);
      check_eq("rst_tdi",  64'(tdi), 64'd0);
      check_eq("rst_rspv", 64'(bus.rsp_valid), 64'd0);
      check_eq("rst_rspd", 64'(bus.rsp_data), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rel_ready", 64'(bus.cmd_ready), 64'd1);

      // 1: DR scan 8 bits of 0xA5 against preloaded 0x3C
      base = rises;
      send_cmd(2'b00, LEN_W'(8), 32'hA5);
      wait_rsp(lat, rdata);
      check_eq("dr_tck_cnt", 64'(rises - base), 64'd13);
      check_eq("dr_tms", tms_seq(base, 13), 64'hC01);
      check_eq("dr_rsp", 64'(rdata), 64'h3C);
      check_eq("dr_model", 64'(dr_reg), 64'hA5);
      check_eq("dr_latency", 64'(lat), 64'd105);
      check_eq("dr_tck_low", 64'(tck), 64'd0);
      check_eq("dr_tms_end", 64'(tms), 64'd0);
      check_eq("dr_tdi_end", 64'(tdi), 64'd0);
      check_eq("dr_tap_rti", 64'(tap_st), 64'(T_RTI));
      consume();

      // 2: IR scan 4 bits of 0x2
      base = rises;
      send_cmd(2'b01, LEN_W'(4), 32'h2);
      wait_rsp(lat, rdata);
      check_eq("ir_tck_cnt", 64'(rises - base), 64'd10);
      check_eq("ir_tms", tms_seq(base, 10), 64'h183);
      check_eq("ir_model", 64'(ir_reg), 64'h2);
      check_eq("ir_rsp", 64'(rdata), 64'h1);
      check_eq("ir_latency", 64'(lat), 64'd81);
      consume();

      // 3: three idle TCK cycles
      base = rises;
      send_cmd(2'b10, LEN_W'(3), 32'hFFFF_FFFF);
      wait_rsp(lat, rdata);
      check_eq("rti_tck_cnt", 64'(rises - base), 64'd3);
      check_eq("rti_tms", tms_seq(base, 3), 64'h0);
      check_eq("rti_rsp", 64'(rdata), 64'h0);
      check_eq("rti_period", 64'(tck_period), 64'(2 * CLK_DIV * 10));
      check_eq("rti_latency", 64'(lat), 64'd25);
      consume();

      // 4a: zero-length scan
      base = rises;
      send_cmd(2'b00, LEN_W'(0), 32'hDEAD_BEEF);
      wait_rsp(lat, rdata);
      check_eq("len0_latency", 64'(lat), 64'd1);
      check_eq("len0_no_tck", 64'(rises - base), 64'd0);
      check_eq("len0_rsp", 64'(rdata), 64'h0);
      consume();

      // 4b: length 40 clamps to 32
      base = rises;
      send_cmd(2'b00, LEN_W'(40), 32'h1234_5678);
      wait_rsp(lat, rdata);
      check_eq("clamp_tck_cnt", 64'(rises - base), 64'd37);
      check_eq("clamp_tms", tms_seq(base, 37), 64'h0000_000C_0000_0001);
      check_eq("clamp_rsp", 64'(rdata), 64'h3456_78A5);
      check_eq("clamp_model", 64'(dr_reg), 64'h12);
      check_eq("clamp_latency", 64'(lat), 64'd297);
      consume();

      // 5: reset in the low half of shift bit 3
      base = rises;
      send_cmd(2'b00, LEN_W'(8), 32'hFF);
      lat = 0;
      while (!((rises - base == 6) && (tck == 1'b0)) && lat < 500) begin
         @(negedge clk);
         lat++;
      end
      check_eq("abort_reached_bit3", 64'(rises - base), 64'd6);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_eq("abort_tck",  64'(tck), 64'd0);
      check_eq("abort_tms",  64'(tms), 64'd1);
      check_eq("abort_busy", 64'(busy), 64'd0);
      check_eq("abort_rspv", 64'(bus.rsp_valid), 64'd0);
      tap_trst = 1'b1;
      #1 tap_trst = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("abort_ready", 64'(bus.cmd_ready), 64'd1);
      repeat (5) @(negedge clk);
      check_eq("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
      check_eq("abort_no_tck", 64'(rises - base), 64'd6);

      // 6: response held while rsp_ready stays low
      send_cmd(2'b00, LEN_W'(8), 32'h5A);
      wait_rsp(lat, rdata);
      check_eq("hold_rsp", 64'(rdata), 64'h12);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_eq("hold_rspv",  64'(bus.rsp_valid), 64'd1);
         check_eq("hold_rspd",  64'(bus.rsp_data), 64'h12);
         check_eq("hold_ready", 64'(bus.cmd_ready), 64'd0);
      end
      consume();
      @(negedge clk);
      check_eq("hold_released", 64'(bus.cmd_ready), 64'd1);
      check_eq("hold_model", 64'(dr_reg), 64'h5A);

      // 6b: op 11 with a nonzero length that must be ignored
      base = rises;
      send_cmd(2'b11, LEN_W'(7), 32'hFFFF_FFFF);
      wait_rsp(lat, rdata);
      check_eq("tlr_rsp", 64'(rdata), 64'h0);
`ifdef JTAG_TAP_DRIVER_TLR_EN
      check_eq("tlr_tck_cnt", 64'(rises - base), 64'd6);
      check_eq("tlr_tms", tms_seq(base, 6), 64'h1F);
      check_eq("tlr_latency", 64'(lat), 64'd49);
`else
      check_eq("tlr_tck_cnt", 64'(rises - base), 64'd0);
      check_eq("tlr_latency", 64'(lat), 64'd1);
`endif
      check_eq("tlr_tap_rti", 64'(tap_st), 64'(T_RTI));
      consume();

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
